gf_alu_2_seq: RTL and testbench
===============================

Name: gf_alu_2_seq

Overview:
- Multi-digit operation sequencer that drives one 2-bit pipelined ALU slice (gf_alu_2 family).
- Accepts WIDTH-bit operands with a valid/ready handshake and splits them into 2-bit digits, LS digit first.
- For arithmetic, chains the ALU carry_out back into carry_in across digits; collects the returning zout digits and presents the assembled result, carry and overflow with a valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; even, ≥2; D = WIDTH/2 digits.
- ALU_LAT, 7, ALU input-to-output latency in clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  sequencer can accept; high only in IDLE
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- op  in  2  0=AND, 1=XOR, 2=ARITH, 3=reserved
- cmpl_x  in  1  complement X (all digits)
- cmpl_y  in  1  complement Y (all digits)
- carry_in  in  1  carry into digit 0 (ARITH only)
- alu_xin  out  2  X digit to ALU
- alu_yin  out  2  Y digit to ALU
- alu_carry_in  out  1  digit carry to ALU
- alu_end_bar  out  1  0 on MS digit issue, else 1
- alu_cmpl_x  out  1  to ALU cmpl_x
- alu_cmpl_y  out  1  to ALU cmpl_y
- alu_op_and  out  1  op==0
- alu_op_xor  out  1  op==1
- alu_op_arith  out  1  op==2
- alu_zout  in  2  ALU result digit
- alu_overflow  in  1  ALU overflow
- alu_carry_out  in  1  ALU carry out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- z  out  WIDTH  result
- cout  out  1  carry out of MS digit
- ovf  out  1  overflow of MS digit

Behaviour:
- Reset: FSM=IDLE; in_ready=1; out_valid=0; z=0; cout=0; ovf=0; all alu_* outputs=0; tag delay line cleared.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: accept on in_valid&in_ready (cycle T0). Latch x, y, op, cmpl_x, cmpl_y, carry_in. Go to ISSUE.
- ISSUE: drive digit k for exactly one cycle: alu_xin=x[2k+1:2k], alu_yin=y[2k+1:2k], plus op/cmpl lines. Push tag {valid,k} into an ALU_LAT-deep delay line.
- Non-issue cycles: alu_xin/alu_yin/alu_carry_in/alu_end_bar/op lines = 0. ALU output is ignored unless a valid tag emerges.
- Capture: when a tag exits the delay line (issue cycle + ALU_LAT), store alu_zout into z[2k+1:2k]. For the MS digit also store cout=alu_carry_out and ovf=alu_overflow.
- Logic ops (op 0, 1, 3):
  - Digits issue back-to-back at T0+1+k; FSM stays in ISSUE, then WAIT until the last capture.
  - alu_carry_in=0; cout/ovf still captured from the MS digit.
- op 3: all op lines low; timing as logic; z content undefined.
- ARITH:
  - Digit 0 issues at T0+1 with alu_carry_in=latched carry_in.
  - Digit k issues one cycle after digit k-1 is captured, using the registered alu_carry_out of digit k-1.
  - Issue of digit k occurs at T0+1+k(ALU_LAT+1).
- DONE: entered the cycle after the last capture; out_valid=1. Hold z/cout/ovf stable until out_valid&out_ready, then go to IDLE with in_ready=1 the next cycle.
- Latency, T0 to first out_valid (D=4, L=7):
  - Logic: T0+D+ALU_LAT+1 (T0+12).
  - ARITH: T0+D(ALU_LAT+1)+1 (T0+33).
- No new request is accepted until DONE completes; one operation in flight.
- rst mid-operation: immediate return to reset state. Tags are discarded, so stale ALU returns are never captured.
- out_ready held low: out_valid stays 1 and outputs are frozen indefinitely.

Decomposition:
- Shared package gf_alu_pkg:
  - op encoding constants (OP_AND, OP_XOR, OP_ARITH).
  - FSM state enum.
  - default ALU_LAT=7.
- One sub-module, gf_alu_tag_line: ALU_LAT-deep shift register of {valid, digit index}, with synchronous clear.

Test Plan:
Bench uses a behavioural 2-bit ALU model with ALU_LAT delay.
1. AND x=0xA5, y=0x3C -> z=0x24; out_valid first at T0+12.
2. XOR x=0xA5, y=0x3C -> z=0x99; digits issue on 4 consecutive cycles.
3. ARITH 0xF0+0x10, carry_in=0 -> z=0x00, cout=1, ovf=0; out_valid at T0+33; digit issues spaced 8 cycles apart.
4. ARITH 0x7F+0x01 -> z=0x80, cout=0, ovf=1. Subtract 0x05−0x07 (cmpl_y=1, carry_in=1) -> z=0xFE, cout=0.
5. Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0; release -> in_ready=1 next cycle.
6. Reset mid-ARITH after digit 1 issues -> all outputs 0 next cycle; a following AND 0xFF&0x0F returns 0x0F with no stale digits.

Source files
------------

// File: rtl/gf_alu_pkg.sv
// gf_alu_pkg -- shared definitions for the gf_alu_2 sequencer slice.
//   OP_*        : operation encodings presented on the request bus
//   seq_state_t : sequencer FSM states
//   ALU_LAT_DEF : default input-to-output latency of the 2-bit ALU slice
package gf_alu_pkg;

    localparam logic [1:0] OP_AND   = 2'd0;
    localparam logic [1:0] OP_XOR   = 2'd1;
    localparam logic [1:0] OP_ARITH = 2'd2;

    localparam int ALU_LAT_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gf_alu_2_seq_if.sv
// gf_alu_2_seq_if -- request/response handshake bus of the sequencer.
//   request : in_valid/in_ready, x, y, op, cmpl_x, cmpl_y, carry_in
//   response: out_valid/out_ready, z, cout, ovf
//   master  : the requester/consumer side
//   slave   : the sequencer side
interface gf_alu_2_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       op;
    logic             cmpl_x;
    logic             cmpl_y;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, op, cmpl_x, cmpl_y, carry_in, out_ready,
        input  in_ready, out_valid, z, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, op, cmpl_x, cmpl_y, carry_in, out_ready,
        output in_ready, out_valid, z, cout, ovf
    );
endinterface

// File: rtl/gf_alu_tag_line.sv
// gf_alu_tag_line -- DEPTH-stage shift register of {valid, digit index}
// that tracks which ALU return belongs to which issued digit.
//   clk, rst           : clock, synchronous active-high clear of all tags
//   push_vld, push_idx : tag entering this cycle
//   pop_vld, pop_idx   : tag leaving after DEPTH cycles
module gf_alu_tag_line #(
    parameter int DEPTH = 7,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [IDX_W-1:0] push_idx,
    output logic             pop_vld,
    output logic [IDX_W-1:0] pop_idx
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= push_vld;
            idx_q[0] <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign pop_vld = vld_q[DEPTH-1];
    assign pop_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/gf_alu_2_seq.sv
// gf_alu_2_seq -- splits WIDTH-bit operations into 2-bit digits (LS first),
// feeds them to a pipelined 2-bit ALU slice and reassembles the result.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response handshake (slave side)
//   alu_*     : digit, carry, end marker and op/complement lines to the ALU,
//               plus its zout/overflow/carry_out returns
module gf_alu_2_seq
    import gf_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    gf_alu_2_seq_if.slave        bus,
    output logic [1:0]           alu_xin,
    output logic [1:0]           alu_yin,
    output logic                 alu_carry_in,
    output logic                 alu_end_bar,
    output logic                 alu_cmpl_x,
    output logic                 alu_cmpl_y,
    output logic                 alu_op_and,
    output logic                 alu_op_xor,
    output logic                 alu_op_arith,
    input  logic [1:0]           alu_zout,
    input  logic                 alu_overflow,
    input  logic                 alu_carry_out
);

    localparam int D     = WIDTH / 2;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] x_q, y_q, z_q;
    logic [1:0]       op_q;
    logic             cx_q, cy_q, carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0] k_q;
    logic             issue, accept;
    logic             cap_vld, cap_last;
    logic [IDX_W-1:0] cap_idx;

    assign issue    = (state == ST_ISSUE);
    assign accept   = (state == ST_IDLE) && bus.in_valid;
    assign cap_last = cap_vld && (cap_idx == LAST);

    gf_alu_tag_line #(.DEPTH(ALU_LAT), .IDX_W(IDX_W)) u_tag_line (
        .clk      (clk),
        .rst      (rst),
        .push_vld (issue),
        .push_idx (k_q),
        .pop_vld  (cap_vld),
        .pop_idx  (cap_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: logic ops stream all digits back-to-back; ARITH issues one
    // digit and waits for its carry to come back before issuing the next.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (op_q == OP_ARITH || k_q == LAST) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cap_last)                           state_nxt = ST_DONE;
                else if (cap_vld && op_q == OP_ARITH)   state_nxt = ST_ISSUE;
            end
            ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, digit counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            cx_q    <= 1'b0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                x_q     <= bus.x;
                y_q     <= bus.y;
                op_q    <= bus.op;
                cx_q    <= bus.cmpl_x;
                cy_q    <= bus.cmpl_y;
                carry_q <= bus.carry_in;
                k_q     <= '0;
                z_q     <= '0;
                cout_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
            if (issue) k_q <= k_q + 1'b1;
            if (cap_vld) begin
                z_q[2*cap_idx +: 2] <= alu_zout;
                // Registered carry feeds the next ARITH digit issue.
                carry_q <= alu_carry_out;
                if (cap_last) begin
                    cout_q <= alu_carry_out;
                    ovf_q  <= alu_overflow;
                end
            end
        end
    end

    // Outputs: ALU lines are live only in the issue cycle of a digit.
    always_comb begin
        alu_xin      = 2'b00;
        alu_yin      = 2'b00;
        alu_carry_in = 1'b0;
        alu_end_bar  = 1'b0;
        alu_cmpl_x   = 1'b0;
        alu_cmpl_y   = 1'b0;
        alu_op_and   = 1'b0;
        alu_op_xor   = 1'b0;
        alu_op_arith = 1'b0;
        if (issue) begin
            alu_xin      = x_q[2*k_q +: 2];
            alu_yin      = y_q[2*k_q +: 2];
            alu_carry_in = (op_q == OP_ARITH) ? carry_q : 1'b0;
            alu_end_bar  = (k_q != LAST);
            alu_cmpl_x   = cx_q;
            alu_cmpl_y   = cy_q;
            alu_op_and   = (op_q == OP_AND);
            alu_op_xor   = (op_q == OP_XOR);
            alu_op_arith = (op_q == OP_ARITH);
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_gf_alu_2_seq.sv
module tb_gf_alu_2_seq;
    import gf_alu_pkg::*;

    localparam int W = 8;
    localparam int L = 7;

    typedef struct packed {
        logic [W-1:0] z;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [1:0] alu_xin, alu_yin, alu_zout;
    logic       alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
    logic       alu_op_and, alu_op_xor, alu_op_arith;
    logic       alu_overflow, alu_carry_out;

    exp_t sb[$];
    int   iss_q[$];

    gf_alu_2_seq_if #(.WIDTH(W)) bus ();

    gf_alu_2_seq #(.WIDTH(W), .ALU_LAT(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .alu_xin       (alu_xin),
        .alu_yin       (alu_yin),
        .alu_carry_in  (alu_carry_in),
        .alu_end_bar   (alu_end_bar),
        .alu_cmpl_x    (alu_cmpl_x),
        .alu_cmpl_y    (alu_cmpl_y),
        .alu_op_and    (alu_op_and),
        .alu_op_xor    (alu_op_xor),
        .alu_op_arith  (alu_op_arith),
        .alu_zout      (alu_zout),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 2-bit ALU slice with L cycles of latency.
    logic [1:0] m_xa, m_ya, m_z;
    logic [2:0] m_sum;
    logic       m_c1, m_c, m_v;
    logic [1:0] pz [L];
    logic       pc [L];
    logic       pv [L];

    always_comb begin
        m_xa  = alu_cmpl_x ? ~alu_xin : alu_xin;
        m_ya  = alu_cmpl_y ? ~alu_yin : alu_yin;
        m_sum = {1'b0, m_xa} + {1'b0, m_ya} + {2'b00, alu_carry_in};
        m_c1  = (m_xa[0] & m_ya[0]) | (m_xa[0] & alu_carry_in) | (m_ya[0] & alu_carry_in);
        m_z   = 2'b00;
        m_c   = 1'b0;
        m_v   = 1'b0;
        if (alu_op_and) m_z = m_xa & m_ya;
        else if (alu_op_xor) m_z = m_xa ^ m_ya;
        else if (alu_op_arith) begin
            m_z = m_sum[1:0];
            m_c = m_sum[2];
            m_v = m_c1 ^ m_sum[2];
        end
    end

    always @(posedge clk) begin
        pz[0] <= m_z;
        pc[0] <= m_c;
        pv[0] <= m_v;
        for (int i = 1; i < L; i++) begin
            pz[i] <= pz[i-1];
            pc[i] <= pc[i-1];
            pv[i] <= pv[i-1];
        end
    end

    assign alu_zout      = pz[L-1];
    assign alu_carry_out = pc[L-1];
    assign alu_overflow  = pv[L-1];

    // Record the cycle of every digit issue.
    always @(negedge clk) begin
        if (alu_op_and | alu_op_xor | alu_op_arith) iss_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t ref_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                    input logic [1:0] o, input logic cx, input logic cy,
                                    input logic ci);
        exp_t         e;
        logic [W-1:0] xa, ya;
        logic [W:0]   s;
        xa = cx ? ~xv : xv;
        ya = cy ? ~yv : yv;
        e  = '0;
        case (o)
            OP_AND: e.z = xa & ya;
            OP_XOR: e.z = xa ^ ya;
            OP_ARITH: begin
                s   = {1'b0, xa} + {1'b0, ya} + {{W{1'b0}}, ci};
                e.z = s[W-1:0];
                e.c = s[W];
                e.v = (xa[W-1] == ya[W-1]) && (s[W-1] != xa[W-1]);
            end
            default: e.z = '0;
        endcase
        return e;
    endfunction

    task automatic drive_req(input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input logic [1:0] o, input logic cx, input logic cy,
                             input logic ci, output int t_acc);
        @(negedge clk);
        iss_q.delete();
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        bus.op       = o;
        bus.cmpl_x   = cx;
        bus.cmpl_y   = cy;
        bus.carry_in = ci;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        t_acc        = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [1:0] o, input logic cx, input logic cy,
                          input logic ci, input int exp_lat, input int exp_gap,
                          input int hold);
        int   t_acc;
        bit   seen;
        exp_t e, snap;
        sb.push_back(ref_op(xv, yv, o, cx, cy, ci));
        drive_req(xv, yv, o, cx, cy, ci, t_acc);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_valid_seen", 32'(seen), 32'd1);
        if (!seen) begin
            void'(sb.pop_front());
            return;
        end
        check("latency", 32'(cyc - (t_acc - 1)), 32'(exp_lat));
        check("issue_count", 32'(iss_q.size()), 32'd4);
        if (iss_q.size() == 4) begin
            check("issue0_cycle", 32'(iss_q[0]), 32'(t_acc));
            for (int k = 1; k < 4; k++)
                check("issue_gap", 32'(iss_q[k] - iss_q[k-1]), 32'(exp_gap));
        end
        snap = '{z: bus.z, c: bus.cout, v: bus.ovf};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_stable", 32'({bus.z, bus.cout, bus.ovf}), 32'({snap.z, snap.c, snap.v}));
        end
        e = sb.pop_front();
        check("z", 32'(bus.z), 32'(e.z));
        check("cout", 32'(bus.cout), 32'(e.c));
        check("ovf", 32'(bus.ovf), 32'(e.v));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("in_ready_after", 32'(bus.in_ready), 32'd1);
        check("out_valid_after", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int  t_acc;
        bit  got2;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.op        = '0;
        bus.cmpl_x    = 1'b0;
        bus.cmpl_y    = 1'b0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_z", 32'(bus.z), 32'd0);
        check("rst_alu_lines", 32'({alu_xin, alu_yin, alu_carry_in, alu_end_bar,
                                   alu_op_and, alu_op_xor, alu_op_arith}), 32'd0);
        rst = 1'b0;

        run_op(8'hA5, 8'h3C, OP_AND,   1'b0, 1'b0, 1'b0, 12, 1, 0);
        run_op(8'hA5, 8'h3C, OP_XOR,   1'b0, 1'b0, 1'b0, 12, 1, 0);
        run_op(8'hF0, 8'h10, OP_ARITH, 1'b0, 1'b0, 1'b0, 33, 8, 0);
        run_op(8'h7F, 8'h01, OP_ARITH, 1'b0, 1'b0, 1'b0, 33, 8, 0);
        run_op(8'h05, 8'h07, OP_ARITH, 1'b0, 1'b1, 1'b1, 33, 8, 20);

        // Reset in the middle of an ARITH operation, right after digit 1 issues.
        drive_req(8'hF0, 8'h10, OP_ARITH, 1'b0, 1'b0, 1'b0, t_acc);
        got2 = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (iss_q.size() >= 2) begin
                got2 = 1'b1;
                break;
            end
        end
        check("mid_rst_digit1", 32'(got2), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out", 32'({bus.out_valid, bus.z, bus.cout, bus.ovf}), 32'd0);
        check("mid_rst_alu", 32'({alu_xin, alu_yin, alu_carry_in, alu_end_bar,
                                 alu_cmpl_x, alu_cmpl_y,
                                 alu_op_and, alu_op_xor, alu_op_arith}), 32'd0);
        run_op(8'hFF, 8'h0F, OP_AND, 1'b0, 1'b0, 1'b0, 12, 1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
